// File: rtl/interrupt_source.sv
// Periodic/software interrupt source: a down-counting timer and a software strobe feed an
// event queue that is drained one pulse at a time, each pulse needing a handler ack.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no pulse in flight; launches as soon as queued > 0
// PULSE    | int_out high for PULSE_LEN cycles
// GAP      | int_out low for GAP_LEN cycles before waiting on the handler
// WAIT_ACK | holds until ack; ack in any other state is dropped
module interrupt_source #(
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] period_in,
    input  logic        sw_trig,
    input  logic        ack,
    input  logic        clr_ovf,
    output logic        int_out,
    output logic [3:0]  queued,
    output logic        overflow,
    output logic        busy,
    output logic [31:0] count
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PULSE    = 2'd1;
    localparam logic [1:0] ST_GAP      = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    localparam logic [3:0] PULSE_INIT = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_INIT   = 4'(GAP_LEN - 1);
    localparam logic [3:0] QUEUE_MAX  = 4'd15;

    logic [31:0] period_q, period_d;
    logic [31:0] count_q, count_d;
    logic [3:0]  queued_q, queued_d;
    logic        overflow_q, overflow_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic        int_q, int_d;
    logic        busy_q, busy_d;

    logic        tick;
    logic        launch;
    logic        ovf_set;
    logic [1:0]  events;
    logic [4:0]  queue_sum;

    // Load takes priority over the decrement and suppresses the tick of that cycle.
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        tick     = 1'b0;
        if (load) begin
            period_d = period_in;
            count_d  = (period_in == '0) ? '0 : period_in - 32'd1;
        end else if (enable && (period_q != '0)) begin
            if (count_q == '0) begin
                tick    = 1'b1;
                count_d = period_q - 32'd1;
            end else begin
                count_d = count_q - 32'd1;
            end
        end
    end

    assign launch    = (state_q == ST_IDLE) && (queued_q != 4'd0);
    assign events    = {1'b0, tick} + {1'b0, sw_trig};
    assign queue_sum = {1'b0, queued_q} + {3'b000, events} - {4'b0000, launch};

    always_comb begin
        queued_d = queue_sum[3:0];
        ovf_set  = 1'b0;
        if (queue_sum > {1'b0, QUEUE_MAX}) begin
            queued_d = QUEUE_MAX;
            ovf_set  = 1'b1;
        end
        overflow_d = ovf_set | (overflow_q & ~clr_ovf);
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_PULSE;
                    phase_d = PULSE_INIT;
                end
            end
            ST_PULSE: begin
                if (phase_q == 4'd0) begin
                    state_d = ST_GAP;
                    phase_d = GAP_INIT;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (phase_q == 4'd0) begin
                    state_d = ST_WAIT_ACK;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    // Outputs are registered off the next state so int_out has no input-to-output path.
    assign int_d  = (state_d == ST_PULSE);
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            period_q   <= '0;
            count_q    <= '0;
            queued_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            int_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            period_q   <= period_d;
            count_q    <= count_d;
            queued_q   <= queued_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            int_q      <= int_d;
            busy_q     <= busy_d;
        end
    end

    assign int_out  = int_q;
    assign queued   = queued_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign count    = count_q;

endmodule

// File: tb/tb_interrupt_source.sv
// Directed bench for interrupt_source: timer, event queue, pulse FSM, overflow and reset.
module tb_interrupt_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [31:0] period_in;
    logic        sw_trig;
    logic        ack;
    logic        clr_ovf;
    logic        int_out;
    logic [3:0]  queued;
    logic        overflow;
    logic        busy;
    logic [31:0] count;

    int checks = 0;
    int errors = 0;

    interrupt_source #(.PULSE_LEN(2), .GAP_LEN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .period_in (period_in),
        .sw_trig   (sw_trig),
        .ack       (ack),
        .clr_ovf   (clr_ovf),
        .int_out   (int_out),
        .queued    (queued),
        .overflow  (overflow),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; load = 1'b0; period_in = '0;
        sw_trig = 1'b0; ack = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; load = 1'b1; period_in = 32'd7;
        sw_trig = 1'b1; ack = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int: got %0b exp 0", int_out); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL reset_queued: got %0d exp 0", queued); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b exp 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        // period stayed 0 under reset, so enabling afterwards must not move the counter
        rst = 1'b1; load = 1'b0; sw_trig = 1'b0;
        step();
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d exp 0", count); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL reset_noevent: got %0d exp 0", queued); end
    endtask

    task automatic test_timer();
        int exp_cnt[9] = '{3, 2, 1, 0, 4, 3, 2, 1, 0};
        logic exp_int[9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        int exp_q[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        do_reset();
        load = 1'b1; period_in = 32'd5; enable = 1'b1;
        step();
        load = 1'b0;
        checks++; if (count !== 32'd4) begin errors++; $display("FAIL timer_load_count: got %0d exp 4", count); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL timer_load_notick: got %0d exp 0", queued); end
        for (int k = 0; k < 9; k++) begin
            step();
            checks++; if (count !== 32'(exp_cnt[k])) begin errors++; $display("FAIL timer_count[%0d]: got %0d exp %0d", k, count, exp_cnt[k]); end
            checks++; if (int_out !== exp_int[k]) begin errors++; $display("FAIL timer_int[%0d]: got %0b exp %0b", k, int_out, exp_int[k]); end
            checks++; if (queued !== 4'(exp_q[k])) begin errors++; $display("FAIL timer_queued[%0d]: got %0d exp %0d", k, queued, exp_q[k]); end
        end
        enable = 1'b0;
        step(); step(); step();
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL timer_hold: got %0d exp 0", count); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL timer_hold_notick: got %0d exp 0", queued); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timer_waitack_busy: got %0b exp 1", busy); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timer_ack_idle: got %0b exp 0", busy); end
    endtask

    task automatic test_load_override();
        do_reset();
        load = 1'b1; period_in = 32'd3; enable = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL ovr_at_zero: got %0d exp 0", count); end
        load = 1'b1; period_in = 32'd6;
        step();
        load = 1'b0;
        checks++; if (count !== 32'd5) begin errors++; $display("FAIL ovr_count: got %0d exp 5", count); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL ovr_notick: got %0d exp 0", queued); end
        for (int k = 0; k < 5; k++) step();
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL ovr_down: got %0d exp 0", count); end
        step();
        enable = 1'b0;
        checks++; if (count !== 32'd5) begin errors++; $display("FAIL ovr_reload: got %0d exp 5", count); end
        checks++; if (queued !== 4'd1) begin errors++; $display("FAIL ovr_tick: got %0d exp 1", queued); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load = 1'b1; period_in = 32'd3; enable = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        sw_trig = 1'b1;
        step();
        sw_trig = 1'b0; enable = 1'b0;
        checks++; if (queued !== 4'd2) begin errors++; $display("FAIL simul_q2: got %0d exp 2", queued); end
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL simul_int_early: got %0b exp 0", int_out); end
        step();
        checks++; if (queued !== 4'd1) begin errors++; $display("FAIL simul_q1: got %0d exp 1", queued); end
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL simul_pulse1: got %0b exp 1", int_out); end
        step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL simul_pulse2: got %0b exp 1", int_out); end
        step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL simul_wait_int[%0d]: got %0b exp 0", k, int_out); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_wait_busy[%0d]: got %0b exp 1", k, busy); end
            step();
        end
        checks++; if (queued !== 4'd1) begin errors++; $display("FAIL simul_wait_q: got %0d exp 1", queued); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_ack_idle: got %0b exp 0", busy); end
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL simul_ack_int: got %0b exp 0", int_out); end
        step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL simul_second_pulse: got %0b exp 1", int_out); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL simul_q0: got %0d exp 0", queued); end
    endtask

    task automatic test_overflow();
        do_reset();
        sw_trig = 1'b1;
        step();
        sw_trig = 1'b0;
        step(); step(); step(); step(); step();
        checks++; if (busy !== 1'b1 || int_out !== 1'b0) begin errors++; $display("FAIL ovf_waitack: got busy=%0b int=%0b exp busy=1 int=0", busy, int_out); end
        for (int k = 1; k <= 16; k++) begin
            sw_trig = 1'b1;
            step();
            sw_trig = 1'b0;
            step();
            if (k == 15) begin
                checks++; if (queued !== 4'd15 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_at15: got q=%0d ovf=%0b exp q=15 ovf=0", queued, overflow); end
            end
        end
        checks++; if (queued !== 4'd15) begin errors++; $display("FAIL ovf_sat: got %0d exp 15", queued); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b exp 1", overflow); end
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b exp 1", overflow); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b exp 0", overflow); end
        checks++; if (queued !== 4'd15) begin errors++; $display("FAIL ovf_clr_q: got %0d exp 15", queued); end
        clr_ovf = 1'b1; sw_trig = 1'b1;
        step();
        clr_ovf = 1'b0; sw_trig = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b exp 1", overflow); end
    endtask

    task automatic test_ack_ignored();
        do_reset();
        sw_trig = 1'b1;
        step();
        sw_trig = 1'b0; ack = 1'b1;
        step();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL ackign_pulse: got %0b exp 1", int_out); end
        step(); step(); step();
        ack = 1'b0;
        checks++; if (int_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ackign_gap: got int=%0b busy=%0b exp int=0 busy=1", int_out, busy); end
        step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ackign_wait[%0d]: got %0b exp 1", k, busy); end
            step();
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ackign_fresh: got %0b exp 0", busy); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        load = 1'b1; period_in = 32'd1; enable = 1'b1;
        step();
        load = 1'b0; sw_trig = 1'b1;
        checks++; if (count !== 32'd0 || queued !== 4'd0) begin errors++; $display("FAIL rmp_load: got cnt=%0d q=%0d exp 0 0", count, queued); end
        step();
        checks++; if (queued !== 4'd2) begin errors++; $display("FAIL rmp_q2: got %0d exp 2", queued); end
        step();
        sw_trig = 1'b0; enable = 1'b0;
        checks++; if (queued !== 4'd3 || int_out !== 1'b1) begin errors++; $display("FAIL rmp_first: got q=%0d int=%0b exp q=3 int=1", queued, int_out); end
        step();
        checks++; if (queued !== 4'd3 || int_out !== 1'b1) begin errors++; $display("FAIL rmp_second: got q=%0d int=%0b exp q=3 int=1", queued, int_out); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL rmp_int: got %0b exp 0", int_out); end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL rmp_queued: got %0d exp 0", queued); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmp_busy: got %0b exp 0", busy); end
        step();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL rmp_stay_low: got %0b exp 0", int_out); end
    endtask

    task automatic test_zero_period();
        do_reset();
        load = 1'b1; period_in = 32'd0; enable = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            checks++; if (count !== 32'd0) begin errors++; $display("FAIL zero_count[%0d]: got %0d exp 0", k, count); end
            checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL zero_int[%0d]: got %0b exp 0", k, int_out); end
        end
        checks++; if (queued !== 4'd0) begin errors++; $display("FAIL zero_queued: got %0d exp 0", queued); end
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timer();
        test_load_override();
        test_simultaneous();
        test_overflow();
        test_ack_ignored();
        test_reset_mid_pulse();
        test_zero_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
